// File: rtl/overpack_pkg.sv
// Shared constants, types and the saturating add used by every accumulator lane.
package overpack_pkg;

    localparam int NUM_LANES  = 6;
    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int SAT_W      = 32;

    typedef logic [2:0] lane_idx_t;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    sat;
    } sat_res_t;

    // Operands arrive sign-extended to SAT_W, so the true sum never wraps for ACC_W <= 30.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                         input logic signed [SAT_W-1:0] prod,
                                         input int                      acc_w);
        sat_res_t                r;
        logic signed [SAT_W-1:0] total;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        total = acc + prod;
        max_v = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
        min_v = -max_v - 32'sd1;
        r.sum = total;
        r.sat = 1'b0;
        if (total > max_v) begin
            r.sum = max_v;
            r.sat = 1'b1;
        end else if (total < min_v) begin
            r.sum = min_v;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: running saturated sum plus sticky saturation flag.
// sum_next/sat_next present the value this lane would hold after the current beat.
module acc_lane
    import overpack_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     en,
    input  logic                     clear,
    input  logic signed [PROD_W-1:0] p,
    output logic signed [ACC_W-1:0]  sum_next,
    output logic                     sat_next
);

    logic signed [ACC_W-1:0] sum_q;
    logic                    sat_q;
    sat_res_t                res;
    logic                    unused_hi;

    always_comb begin
        res      = sat_add(SAT_W'(sum_q), SAT_W'(p), ACC_W);
        sum_next = res.sum[ACC_W-1:0];
        sat_next = sat_q | res.sat;
    end

    // Clamped upper bits are always pure sign extension of sum_next.
    assign unused_hi = ^res.sum[SAT_W-1:ACC_W];

    always_ff @(posedge CLK) begin
        if (RST || (en && clear)) begin
            sum_q <= '0;
            sat_q <= 1'b0;
        end else if (en) begin
            sum_q <= sum_next;
            sat_q <= sat_next;
        end
    end

endmodule

// File: rtl/overpack_accumulator.sv
// Six-lane saturating dot-product accumulator with a double-buffered output set.
// Build option: define RELU_OUT_EN to load negative final sums into acc* as zero.
module overpack_accumulator
    import overpack_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int BEATS  = 49
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] p1,
    input  logic signed [PROD_W-1:0] p2,
    input  logic signed [PROD_W-1:0] p3,
    input  logic signed [PROD_W-1:0] p4,
    input  logic signed [PROD_W-1:0] p5,
    input  logic signed [PROD_W-1:0] p6,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  acc0,
    output logic signed [ACC_W-1:0]  acc1,
    output logic signed [ACC_W-1:0]  acc2,
    output logic signed [ACC_W-1:0]  acc3,
    output logic signed [ACC_W-1:0]  acc4,
    output logic signed [ACC_W-1:0]  acc5,
    output logic [NUM_LANES-1:0]     out_sat
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]        beat_cnt;
    logic                    last_cnt;
    logic                    accept;
    logic                    last_accept;
    logic signed [PROD_W-1:0] p_arr     [NUM_LANES];
    logic signed [ACC_W-1:0]  lane_next [NUM_LANES];
    logic signed [ACC_W-1:0]  acc_q     [NUM_LANES];
    logic [NUM_LANES-1:0]     lane_sat_next;

    assign p_arr[0] = p1;
    assign p_arr[1] = p2;
    assign p_arr[2] = p3;
    assign p_arr[3] = p4;
    assign p_arr[4] = p5;
    assign p_arr[5] = p6;

    // Handshakes: a beat transfers when in_valid & in_ready, a set when out_valid & out_ready.
    // Only the closing beat of a set can stall, and only while the held set is unclaimed.
    assign last_cnt    = (beat_cnt == CNT_W'(BEATS - 1));
    assign in_ready    = !(last_cnt && out_valid && !out_ready);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && last_cnt;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        acc_lane #(
            .PROD_W(PROD_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .CLK     (CLK),
            .RST     (RST),
            .en      (accept),
            .clear   (last_accept),
            .p       (p_arr[i]),
            .sum_next(lane_next[i]),
            .sat_next(lane_sat_next[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_sat   <= '0;
            for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
        end else begin
            if (accept) beat_cnt <= last_cnt ? '0 : beat_cnt + 1'b1;
            if (last_accept) begin
                out_valid <= 1'b1;
                out_sat   <= lane_sat_next;
                for (int i = 0; i < NUM_LANES; i++) begin
`ifdef RELU_OUT_EN
                    acc_q[i] <= lane_next[i][ACC_W-1] ? '0 : lane_next[i];
`else
                    acc_q[i] <= lane_next[i];
`endif
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign acc0 = acc_q[0];
    assign acc1 = acc_q[1];
    assign acc2 = acc_q[2];
    assign acc3 = acc_q[3];
    assign acc4 = acc_q[4];
    assign acc5 = acc_q[5];

endmodule

// File: tb/tb_overpack_accumulator.sv
// Self-checking bench: three parameterisations of overpack_accumulator against an integer model.
module tb_overpack_accumulator;
    import overpack_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // dut_a: BEATS=4, ACC_W=16
    logic              a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic signed [7:0]  a_p   [6];
    logic signed [15:0] a_acc [6];
    logic [5:0]         a_sat;
    // dut_b: BEATS=8, ACC_W=10
    logic              b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic signed [7:0] b_p   [6];
    logic signed [9:0] b_acc [6];
    logic [5:0]        b_sat;
    // dut_c: BEATS=1, ACC_W=16
    logic              c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic signed [7:0]  c_p   [6];
    logic signed [15:0] c_acc [6];
    logic [5:0]         c_sat;

    overpack_accumulator #(.PROD_W(8), .ACC_W(16), .BEATS(4)) dut_a (
        .CLK(CLK), .RST(RST), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .p1(a_p[0]), .p2(a_p[1]), .p3(a_p[2]), .p4(a_p[3]), .p5(a_p[4]), .p6(a_p[5]),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .acc0(a_acc[0]), .acc1(a_acc[1]), .acc2(a_acc[2]), .acc3(a_acc[3]), .acc4(a_acc[4]), .acc5(a_acc[5]),
        .out_sat(a_sat));

    overpack_accumulator #(.PROD_W(8), .ACC_W(10), .BEATS(8)) dut_b (
        .CLK(CLK), .RST(RST), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .p1(b_p[0]), .p2(b_p[1]), .p3(b_p[2]), .p4(b_p[3]), .p5(b_p[4]), .p6(b_p[5]),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc0(b_acc[0]), .acc1(b_acc[1]), .acc2(b_acc[2]), .acc3(b_acc[3]), .acc4(b_acc[4]), .acc5(b_acc[5]),
        .out_sat(b_sat));

    overpack_accumulator #(.PROD_W(8), .ACC_W(16), .BEATS(1)) dut_c (
        .CLK(CLK), .RST(RST), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .p1(c_p[0]), .p2(c_p[1]), .p3(c_p[2]), .p4(c_p[3]), .p5(c_p[4]), .p6(c_p[5]),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .acc0(c_acc[0]), .acc1(c_acc[1]), .acc2(c_acc[2]), .acc3(c_acc[3]), .acc4(c_acc[4]), .acc5(c_acc[5]),
        .out_sat(c_sat));

    // Reference model: plain integer sums clamped to the signed ACC_W range.
    int m_sum [6];
    bit m_f   [6];
    int held_sum [6];
    bit held_f   [6];

    function automatic void model_clear();
        for (int i = 0; i < 6; i++) begin
            m_sum[i] = 0;
            m_f[i]   = 0;
        end
    endfunction

    function automatic void model_add(int lane, int pv, int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        int t  = m_sum[lane] + pv;
        if (t > hi) begin
            t = hi;
            m_f[lane] = 1;
        end else if (t < lo) begin
            t = lo;
            m_f[lane] = 1;
        end
        m_sum[lane] = t;
    endfunction

    function automatic int exp_out(int v);
`ifdef RELU_OUT_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [5:0] flags_vec(input bit f [6]);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = f[i];
        return r;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        a_in_valid = 1; b_in_valid = 1; c_in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            a_p[i] = 8'($urandom_range(0, 255));
            b_p[i] = 8'($urandom_range(0, 255));
            c_p[i] = 8'($urandom_range(0, 255));
        end
        step();
        step();
        RST = 1'b0;
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        #1;
        n_checks++;
        if ({a_out_valid, b_out_valid, c_out_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=000", {a_out_valid, b_out_valid, c_out_valid});
        end
        n_checks++;
        if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=111", {a_in_ready, b_in_ready, c_in_ready});
        end
        n_checks++;
        if ({a_sat, b_sat, c_sat} !== 18'd0) begin
            n_fail++; $display("FAIL reset_out_sat got=%b/%b/%b exp=0", a_sat, b_sat, c_sat);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (a_acc[i] !== 16'sd0 || b_acc[i] !== 10'sd0 || c_acc[i] !== 16'sd0) begin
                n_fail++; $display("FAIL reset_acc%0d got=%0d/%0d/%0d exp=0", i, a_acc[i], b_acc[i], c_acc[i]);
            end
        end
    endtask

    task automatic test_basic();
        int pv [6] = '{1, 2, 3, -1, -2, -3};
        model_clear();
        a_out_ready = 1;
        for (int b = 0; b < 4; b++) begin
            a_in_valid = 1;
            for (int i = 0; i < 6; i++) begin
                a_p[i] = 8'(pv[i]);
                model_add(i, pv[i], 16);
            end
            n_checks++;
            if (a_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL basic_in_ready beat=%0d got=%b exp=1", b, a_in_ready);
            end
            step();
        end
        a_in_valid = 0;
        n_checks++;
        if (a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_out_valid got=%b exp=1", a_out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (a_acc[i] !== 16'(exp_out(m_sum[i]))) begin
                n_fail++; $display("FAIL basic_acc%0d got=%0d exp=%0d", i, a_acc[i], exp_out(m_sum[i]));
            end
        end
        n_checks++;
        if (a_sat !== 6'b0) begin
            n_fail++; $display("FAIL basic_out_sat got=%b exp=000000", a_sat);
        end
        step();
        n_checks++;
        if (a_out_valid !== 1'b0 || a_acc[0] !== 16'sd4) begin
            n_fail++; $display("FAIL basic_after_take got valid=%b acc0=%0d exp valid=0 acc0=4", a_out_valid, a_acc[0]);
        end
    endtask

    task automatic test_saturation();
        model_clear();
        b_out_ready = 1;
        for (int b = 0; b < 8; b++) begin
            b_in_valid = 1;
            b_p[0] = 8'sd127;
            b_p[1] = -8'sd128;
            for (int i = 2; i < 6; i++) b_p[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 6; i++) model_add(i, int'(b_p[i]), 10);
            step();
        end
        b_in_valid = 0;
        n_checks++;
        if (b_out_valid !== 1'b1 || b_acc[0] !== 10'sd511 || b_sat[0] !== 1'b1) begin
            n_fail++; $display("FAIL sat_pos got valid=%b acc0=%0d sat0=%b exp 1/511/1", b_out_valid, b_acc[0], b_sat[0]);
        end
        n_checks++;
        if (b_acc[1] !== 10'(exp_out(-512)) || b_sat[1] !== 1'b1) begin
            n_fail++; $display("FAIL sat_neg got acc1=%0d sat1=%b exp %0d/1", b_acc[1], b_sat[1], exp_out(-512));
        end
        for (int i = 2; i < 6; i++) begin
            n_checks++;
            if (b_acc[i] !== 10'(exp_out(m_sum[i]))) begin
                n_fail++; $display("FAIL sat_acc%0d got=%0d exp=%0d", i, b_acc[i], exp_out(m_sum[i]));
            end
        end
        n_checks++;
        if (b_sat !== flags_vec(m_f)) begin
            n_fail++; $display("FAIL sat_flags got=%b exp=%b", b_sat, flags_vec(m_f));
        end
        step();
    endtask

    task automatic test_backpressure();
        int set_a [6];
        a_out_ready = 0;
        model_clear();
        for (int b = 0; b < 4; b++) begin
            a_in_valid = 1;
            for (int i = 0; i < 6; i++) begin
                a_p[i] = 8'($urandom_range(0, 255));
                model_add(i, int'(a_p[i]), 16);
            end
            step();
        end
        for (int i = 0; i < 6; i++) set_a[i] = exp_out(m_sum[i]);
        model_clear();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 6; i++) a_p[i] = 8'($urandom_range(0, 255));
            #1;
            n_checks++;
            if (a_in_ready !== (b < 3)) begin
                n_fail++; $display("FAIL bp_in_ready beat=%0d got=%b exp=%b", b, a_in_ready, b < 3);
            end
            if (b < 3) begin
                for (int i = 0; i < 6; i++) model_add(i, int'(a_p[i]), 16);
                step();
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_stall got valid=%b ready=%b exp 1/0", a_out_valid, a_in_ready);
            end
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (a_acc[i] !== 16'(set_a[i])) begin
                    n_fail++; $display("FAIL bp_hold_acc%0d got=%0d exp=%0d", i, a_acc[i], set_a[i]);
                end
            end
        end
        a_out_ready = 1;
        for (int i = 0; i < 6; i++) model_add(i, int'(a_p[i]), 16);
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready got=%b exp=1", a_in_ready);
        end
        step();
        a_in_valid = 0;
        n_checks++;
        if (a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_no_bubble got valid=%b exp=1", a_out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (a_acc[i] !== 16'(exp_out(m_sum[i]))) begin
                n_fail++; $display("FAIL bp_setb_acc%0d got=%0d exp=%0d", i, a_acc[i], exp_out(m_sum[i]));
            end
        end
        step();
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain got valid=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int exp_l [6];
        c_out_ready = 1;
        for (int n = 1; n <= 20; n++) begin
            c_in_valid = 1;
            c_p[0] = 8'(n);
            exp_l[0] = n;
            for (int i = 1; i < 6; i++) begin
                c_p[i] = 8'($urandom_range(0, 255));
                exp_l[i] = exp_out(int'(c_p[i]));
            end
            n_checks++;
            if (c_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_in_ready n=%0d got=%b exp=1", n, c_in_ready);
            end
            step();
            n_checks++;
            if (c_out_valid !== 1'b1 || c_acc[0] !== 16'(n)) begin
                n_fail++; $display("FAIL b2b_acc0 n=%0d got valid=%b acc0=%0d exp 1/%0d", n, c_out_valid, c_acc[0], n);
            end
            for (int i = 1; i < 6; i++) begin
                n_checks++;
                if (c_acc[i] !== 16'(exp_l[i])) begin
                    n_fail++; $display("FAIL b2b_acc%0d n=%0d got=%0d exp=%0d", i, n, c_acc[i], exp_l[i]);
                end
            end
        end
        c_in_valid = 0;
        step();
        n_checks++;
        if (c_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain got valid=%b exp=0", c_out_valid);
        end
    endtask

    task automatic test_reset_midset();
        a_out_ready = 0;
        for (int b = 0; b < 6; b++) begin
            a_in_valid = 1;
            for (int i = 0; i < 6; i++) a_p[i] = 8'sd5;
            step();
        end
        a_in_valid = 0;
        RST = 1;
        step();
        RST = 0;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_drop got valid=%b ready=%b exp 0/1", a_out_valid, a_in_ready);
        end
        a_out_ready = 1;
        for (int b = 0; b < 4; b++) begin
            a_in_valid = 1;
            a_p[0] = 8'sd1;
            for (int i = 1; i < 6; i++) a_p[i] = 8'sd0;
            step();
        end
        a_in_valid = 0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_acc[0] !== 16'sd4 || a_acc[1] !== 16'sd0) begin
            n_fail++; $display("FAIL rst_mid_residue got valid=%b acc0=%0d acc1=%0d exp 1/4/0", a_out_valid, a_acc[0], a_acc[1]);
        end
        step();
    endtask

    task automatic test_random();
        int  cnt  = 0;
        bit  held = 0;
        bit  exp_rdy;
        bit  acc_ok;
        RST = 1;
        a_in_valid = 0;
        step();
        RST = 0;
        model_clear();
        for (int cyc = 0; cyc < 400; cyc++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 6; i++) a_p[i] = 8'($urandom_range(0, 255));
            #1;
            exp_rdy = !(cnt == 3 && held && !a_out_ready);
            n_checks++;
            if (a_in_ready !== exp_rdy || a_out_valid !== held) begin
                n_fail++; $display("FAIL rand_ctrl cyc=%0d got ready=%b valid=%b exp %b/%b", cyc, a_in_ready, a_out_valid, exp_rdy, held);
            end
            if (held) begin
                acc_ok = 1;
                for (int i = 0; i < 6; i++) if (a_acc[i] !== 16'(exp_out(held_sum[i]))) acc_ok = 0;
                n_checks++;
                if (!acc_ok || a_sat !== flags_vec(held_f)) begin
                    n_fail++; $display("FAIL rand_set cyc=%0d got acc0=%0d sat=%b exp acc0=%0d sat=%b", cyc, a_acc[0], a_sat, exp_out(held_sum[0]), flags_vec(held_f));
                end
            end
            if (a_in_valid && exp_rdy) begin
                for (int i = 0; i < 6; i++) model_add(i, int'(a_p[i]), 16);
                if (cnt == 3) begin
                    held_sum = m_sum;
                    held_f   = m_f;
                    held     = 1;
                    model_clear();
                    cnt = 0;
                end else begin
                    cnt++;
                    if (held && a_out_ready) held = 0;
                end
            end else if (held && a_out_ready) begin
                held = 0;
            end
            @(posedge CLK);
            #1;
        end
        a_in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_midset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
